// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 8-digit 7-segment scan driver.
//   SEG_TABLE   : hex nibble -> active-high segments, bit order gfedcba
//   SEG_A..SEG_DP : bit positions on the segment bus
//   state_e     : scan FSM states
package seg7_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_scan8_if.sv
// seg7_scan8_if: display data in and scan drive out for seg7_scan8.
//   digits     : eight hex nibbles, nibble i = digit i
//   dp_mask    : per-digit decimal point
//   blank_mask : per-digit force-dark
//   brightness : PWM level, 0 = 1/16 .. 15 = 16/16
//   dataout    : segment bus (bit0..6 = a..g, bit7 = dp)
//   en         : digit enables
//   frame_tick : one-cycle pulse at frame load
// master = upstream sequencer, slave = scan driver.
interface seg7_scan8_if;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic [7:0]  blank_mask;
  logic [3:0]  brightness;
  logic [7:0]  dataout;
  logic [7:0]  en;
  logic        frame_tick;

  modport master (
    output digits, dp_mask, blank_mask, brightness,
    input  dataout, en, frame_tick
  );

  modport slave (
    input  digits, dp_mask, blank_mask, brightness,
    output dataout, en, frame_tick
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-high gfedcba segments.
//   nibble_i : hex code
//   seg_o    : segments a..g in bits 0..6, no polarity or dp applied
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan8.sv
// seg7_scan8: eight-digit multiplexed 7-segment scan driver.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   scan_if : seg7_scan8_if.slave (display inputs, segment/enable outputs)
// Each frame is one LOAD cycle that snapshots the inputs, followed by eight
// digit slots of BLANK_CYCLES dead time plus ON_LEN lit time. During ON the
// lit time is split into 16 PWM sub-slots; the digit is enabled for sub-slots
// 0..brightness. All outputs are registered.
module seg7_scan8
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 8192,
  parameter int unsigned BLANK_CYCLES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          EN_ACTIVE_LOW  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan8_if.slave  scan_if
);

  localparam int unsigned ON_LEN = CLK_DIV - BLANK_CYCLES;
  localparam int unsigned SLOT   = ON_LEN / 16;
  localparam int          CW     = $clog2(CLK_DIV);
  localparam int          SW     = (SLOT > 1) ? $clog2(SLOT) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_LEN - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SLOT - 1);

  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] EN_OFF  = EN_ACTIVE_LOW  ? 8'hFF : 8'h00;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // sub_q/slot_q track cnt/SLOT incrementally so no divider is needed
  logic [SW-1:0] sub_q, sub_d;
  logic [3:0]    slot_q, slot_d;

  logic [31:0]   sh_digits_q, sh_digits_d;
  logic [7:0]    sh_dp_q, sh_dp_d;
  logic [7:0]    sh_blank_q, sh_blank_d;
  logic [3:0]    sh_bright_q, sh_bright_d;

  logic          frame_tick_q, frame_tick_d;
  logic [7:0]    en_q, en_d;
  logic [7:0]    seg_q, seg_d;

  logic [6:0]    dec_seg;
  logic          lit;
  logic [7:0]    en_act;
  logic [7:0]    seg_act;

  // Decode from the shadow using the next digit index so the registered
  // segment value lines up with the registered enable.
  seg7_decode u_decode (
    .nibble_i (sh_digits_q[{idx_d, 2'b00} +: 4]),
    .seg_o    (dec_seg)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    sub_d        = sub_q;
    slot_d       = slot_q;
    sh_digits_d  = sh_digits_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    sh_bright_d  = sh_bright_q;
    frame_tick_d = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (!frame_tick_q) begin
          // Reset leaves LOAD pending: announce it with frame_tick first,
          // then perform the actual load on the following edge.
          frame_tick_d = 1'b1;
        end else begin
          sh_digits_d = scan_if.digits;
          sh_dp_d     = scan_if.dp_mask;
          sh_blank_d  = scan_if.blank_mask;
          sh_bright_d = scan_if.brightness;
          idx_d       = 3'd0;
          cnt_d       = '0;
          state_d     = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          sub_d   = '0;
          slot_d  = 4'd0;
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d      = ST_LOAD;
            frame_tick_d = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_BLANK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (sub_q == SUB_LAST) begin
            sub_d  = '0;
            slot_d = slot_q + 4'd1;
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    lit     = (state_d == ST_ON) && (slot_d <= sh_bright_q) && !sh_blank_q[idx_d];
    en_act  = lit ? (8'h01 << idx_d) : 8'h00;
    seg_act = 8'h00;
    if (lit) begin
      seg_act[6:0]    = dec_seg;
      seg_act[SEG_DP] = sh_dp_q[idx_d];
    end
    en_d  = en_act ^ EN_OFF;
    seg_d = seg_act ^ SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      sub_q        <= '0;
      slot_q       <= 4'd0;
      sh_digits_q  <= 32'h0;
      sh_dp_q      <= 8'h00;
      sh_blank_q   <= 8'h00;
      sh_bright_q  <= 4'h0;
      frame_tick_q <= 1'b0;
      en_q         <= EN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      sub_q        <= sub_d;
      slot_q       <= slot_d;
      sh_digits_q  <= sh_digits_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      sh_bright_q  <= sh_bright_d;
      frame_tick_q <= frame_tick_d;
      en_q         <= en_d;
      seg_q        <= seg_d;
    end
  end

  assign scan_if.frame_tick = frame_tick_q;
  assign scan_if.en         = en_q;
  assign scan_if.dataout    = seg_q;

endmodule

// File: tb/tb_seg7_scan8.sv
module tb_seg7_scan8;

  localparam int CLK   = 64;
  localparam int BLK   = 16;
  localparam int SLT   = (CLK - BLK) / 16;
  localparam int FRAME = 1 + 8 * CLK;

  logic clk;
  logic rst;
  seg7_scan8_if bus_if ();

  seg7_scan8 #(
    .CLK_DIV        (CLK),
    .BLANK_CYCLES   (BLK),
    .SEG_ACTIVE_LOW (1'b1),
    .EN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scan_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int model_t;
  logic [31:0] s_dig;
  logic [7:0]  s_dp;
  logic [7:0]  s_bl;
  logic [3:0]  s_br;

  typedef struct {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [3:0]  bright;
    int          t;
    logic        ft;
    logic [7:0]  en;
    logic [7:0]  dout;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  // Active-low segment pattern of a hex digit, dp dark.
  function automatic logic [7:0] hex_al(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Expected {frame_tick, en, dataout} at cycle t of a frame (t=0 is LOAD).
  function automatic logic [16:0] model_out(input int t, input logic [31:0] dg,
                                            input logic [7:0] dp, input logic [7:0] bl,
                                            input logic [3:0] br);
    int u, d, c, k, s;
    logic [7:0] e, o;
    if (t == 0) return {1'b1, 8'hFF, 8'hFF};
    u = t - 1;
    d = u / CLK;
    c = u % CLK;
    if (c < BLK) return {1'b0, 8'hFF, 8'hFF};
    k = c - BLK;
    s = k / SLT;
    if (s <= int'(br) && bl[d] == 1'b0) begin
      e = ~(8'h01 << d);
      o = hex_al(dg[4*d +: 4]);
      if (dp[d]) o[7] = 1'b0;
      return {1'b0, e, o};
    end
    return {1'b0, 8'hFF, 8'hFF};
  endfunction

  function automatic logic [16:0] act();
    return {bus_if.frame_tick, bus_if.en, bus_if.dataout};
  endfunction

  task automatic chk(input string name, input logic [16:0] a, input logic [16:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0d got ft=%b en=%h dout=%h want ft=%b en=%h dout=%h",
               name, model_t, a[16], a[15:8], a[7:0], e[16], e[15:8], e[7:0]);
    end
  endtask

  task automatic set_inputs(input logic [31:0] dg, input logic [7:0] dp,
                            input logic [7:0] bl, input logic [3:0] br);
    bus_if.digits     = dg;
    bus_if.dp_mask    = dp;
    bus_if.blank_mask = bl;
    bus_if.brightness = br;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(negedge clk);
      chk("reset", act(), {1'b0, 8'hFF, 8'hFF});
    end
  endtask

  task automatic release_rst();
    rst = 1'b0;
    @(negedge clk);
    model_t = 0;
    chk("load", act(), model_out(0, s_dig, s_dp, s_bl, s_br));
  endtask

  // Advance one cycle and compare against the model; the shadow snapshot is
  // taken from whatever inputs are present across the LOAD capture edge.
  task automatic tick();
    if (model_t == 0) begin
      s_dig = bus_if.digits;
      s_dp  = bus_if.dp_mask;
      s_bl  = bus_if.blank_mask;
      s_br  = bus_if.brightness;
    end
    @(negedge clk);
    model_t = (model_t == FRAME - 1) ? 0 : model_t + 1;
    chk("model", act(), model_out(model_t, s_dig, s_dp, s_bl, s_br));
  endtask

  task automatic run_to(input int t);
    int guard;
    guard = 0;
    while (model_t != t && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    if (model_t != t) chk("run_to_timeout", 17'(model_t), 17'(t));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_t  = 0;
    s_dig = '0; s_dp = '0; s_bl = '0; s_br = '0;
    rst = 1'b1;
    set_inputs(32'h0, 8'h00, 8'h00, 4'hF);

    vecs[0]  = '{32'h76543210, 8'h00, 8'h00, 4'hF,   0, 1'b1, 8'hFF, 8'hFF};
    vecs[1]  = '{32'h76543210, 8'h00, 8'h00, 4'hF,   1, 1'b0, 8'hFF, 8'hFF};
    vecs[2]  = '{32'h76543210, 8'h00, 8'h00, 4'hF,  16, 1'b0, 8'hFF, 8'hFF};
    vecs[3]  = '{32'h76543210, 8'h00, 8'h00, 4'hF,  17, 1'b0, 8'hFE, 8'hC0};
    vecs[4]  = '{32'h76543210, 8'h00, 8'h00, 4'hF,  64, 1'b0, 8'hFE, 8'hC0};
    vecs[5]  = '{32'h76543210, 8'h00, 8'h00, 4'hF,  65, 1'b0, 8'hFF, 8'hFF};
    vecs[6]  = '{32'h76543210, 8'h00, 8'h00, 4'hF,  81, 1'b0, 8'hFD, 8'hF9};
    vecs[7]  = '{32'h76543210, 8'h00, 8'h00, 4'h0,  19, 1'b0, 8'hFE, 8'hC0};
    vecs[8]  = '{32'h76543210, 8'h00, 8'h00, 4'h0,  20, 1'b0, 8'hFF, 8'hFF};
    vecs[9]  = '{32'h00000000, 8'h01, 8'h80, 4'hF,  17, 1'b0, 8'hFE, 8'h40};
    vecs[10] = '{32'h00000000, 8'h01, 8'h80, 4'hF, 465, 1'b0, 8'hFF, 8'hFF};
    vecs[11] = '{32'h00000000, 8'h01, 8'h80, 4'hF, 512, 1'b0, 8'hFF, 8'hFF};
    vecs[12] = '{32'h76543210, 8'h00, 8'h00, 4'h7,  40, 1'b0, 8'hFE, 8'hC0};
    vecs[13] = '{32'h76543210, 8'h00, 8'h00, 4'h7,  41, 1'b0, 8'hFF, 8'hFF};
    vecs[14] = '{32'h76543210, 8'h00, 8'h00, 4'hF, 337, 1'b0, 8'hDF, 8'h92};
    vecs[15] = '{32'hFEDCBA98, 8'h80, 8'h00, 4'hF, 465, 1'b0, 8'h7F, 8'h0E};
    vecs[16] = '{32'hFEDCBA98, 8'h00, 8'h00, 4'hF, 145, 1'b0, 8'hFB, 8'h88};

    // Reset and frame_tick period
    do_reset(3);
    release_rst();
    repeat (FRAME) tick();
    chk("tick_period", {31'(0), act()} == {31'(0), act()} ? 17'(bus_if.frame_tick) : 17'h0, 17'h1);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      do_reset(2);
      set_inputs(vecs[i].digits, vecs[i].dp, vecs[i].blank, vecs[i].bright);
      release_rst();
      run_to(vecs[i].t);
      chk($sformatf("vec%0d", i), act(), {vecs[i].ft, vecs[i].en, vecs[i].dout});
    end

    // Anti-tearing: inputs change mid-frame, visible only after next LOAD
    do_reset(2);
    set_inputs(32'h0, 8'h00, 8'h00, 4'hF);
    release_rst();
    run_to(149);
    bus_if.digits = 32'hFFFFFFFF;
    run_to(465);
    chk("tear_old_d7", act(), {1'b0, 8'h7F, 8'hC0});
    run_to(0);
    chk("tear_tick", 17'(bus_if.frame_tick), 17'h1);
    run_to(145);
    chk("tear_new_d2", act(), {1'b0, 8'hFB, 8'h8E});

    // Reset during digit 3 ON
    run_to(213);
    do_reset(1);
    release_rst();
    repeat (BLK) tick();
    chk("rst_mid_blank", act(), {1'b0, 8'hFF, 8'hFF});
    tick();
    chk("rst_mid_d0", act(), {1'b0, 8'hFE, 8'h8E});

    // Randomized run against the model
    do_reset(2);
    set_inputs($urandom, 8'($urandom), 8'($urandom), 4'($urandom));
    release_rst();
    for (int n = 0; n < 3 * FRAME; n++) begin
      tick();
      if ($urandom_range(0, 15) == 0)
        set_inputs($urandom, 8'($urandom), 8'($urandom), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
